// File: rtl/ddr_cmd_pkg.sv
// ddr_cmd_pkg
// Shared definitions for the DDR emulation command bus: width of the one-hot
// command vector, the bit position of each command, and the issuer FSM state
// encoding (also used by the chip-side decoders).
// Ports: none (package).

package ddr_cmd_pkg;

    localparam int CMD_WIDTH = 19;

    localparam int CMD_ACT  = 0;
    localparam int CMD_PRE  = 1;
    localparam int CMD_PREA = 2;
    localparam int CMD_RD   = 3;
    localparam int CMD_WR   = 4;
    localparam int CMD_REF  = 5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT_RP,
        ST_ACT,
        ST_WAIT_RCD,
        ST_RW,
        ST_WAIT_BURST,
        ST_PREA,
        ST_WAIT_RP_ALL,
        ST_REF,
        ST_WAIT_RFC
    } ddr_state_e;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ddr_cmd_issuer_if.sv
// ddr_cmd_issuer_if
// Request handshake between a traffic source and the command issuer.
// Ports (signals):
//   req_valid  request present
//   req_ready  request accepted when req_valid && req_ready at a rising edge
//   req_we     1 = write, 0 = read
//   req_addr   {row, ba, bg, column}
// Modports: master = request source, slave = issuer.

interface ddr_cmd_issuer_if #(
    parameter int AW = 31
) ();
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;

    modport master (output req_valid, output req_we, output req_addr, input req_ready);
    modport slave  (input req_valid, input req_we, input req_addr, output req_ready);
endinterface

// File: rtl/ddr_open_row_table.sv
// ddr_open_row_table
// One entry per bank (valid bit + open row). Combinational lookup of the
// incoming request, plus set (ACT), clear (PRE) and clear-all (PREA) updates.
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   lk_idx_i, lk_row_i        bank index and row to look up
//   lk_valid_o, lk_hit_o      bank has an open row / open row matches
//   wr_idx_i                  bank index for set/clear
//   set_en_i, set_row_i       mark bank open with the given row
//   clr_en_i                  close bank wr_idx_i
//   clr_all_i                 close every bank

module ddr_open_row_table #(
    parameter int IDX_W = 4,
    parameter int ROW_W = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] lk_idx_i,
    input  logic [ROW_W-1:0] lk_row_i,
    output logic             lk_valid_o,
    output logic             lk_hit_o,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             set_en_i,
    input  logic [ROW_W-1:0] set_row_i,
    input  logic             clr_en_i,
    input  logic             clr_all_i
);
    localparam int N = 2**IDX_W;

    logic [N-1:0]     valid_q;
    logic [ROW_W-1:0] row_q [N];

    assign lk_valid_o = valid_q[lk_idx_i];
    assign lk_hit_o   = valid_q[lk_idx_i] && (row_q[lk_idx_i] == lk_row_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < N; i++) row_q[i] <= '0;
        end else begin
            if (clr_all_i) begin
                valid_q <= '0;
            end else if (clr_en_i) begin
                valid_q[wr_idx_i] <= 1'b0;
            end else if (set_en_i) begin
                valid_q[wr_idx_i] <= 1'b1;
                row_q[wr_idx_i]   <= set_row_i;
            end
        end
    end

endmodule

// File: rtl/ddr_cmd_issuer.sv
// ddr_cmd_issuer
// Issues PRE/ACT/RD/WR sequences for single-burst requests, tracking the open
// row of each bank. tRP, tRCD and burst spacing come from one down-counter.
// Optional periodic refresh (PREA + REF) is built when REFRESH_EN is defined.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   halt          freeze: no state/counter/table update, commands forced 0
//   req           request handshake (slave modport)
//   commands      one-hot command, 0 = NOP
//   bg, ba        bank group / bank of the current sequence
//   row, column   row for ACT / column for RD-WR (hold last driven value)
//   busy          FSM not in IDLE
//
// state          | meaning
// ST_IDLE        | ready for a request (or start a pending refresh)
// ST_PRE         | close the conflicting row in the target bank
// ST_WAIT_RP     | tRP after PRE
// ST_ACT         | open the requested row
// ST_WAIT_RCD    | tRCD after ACT
// ST_RW          | issue RD or WR
// ST_WAIT_BURST  | burst spacing before the next request
// ST_PREA        | close all banks ahead of refresh
// ST_WAIT_RP_ALL | tRP after PREA
// ST_REF         | refresh
// ST_WAIT_RFC    | tRFC after REF

module ddr_cmd_issuer
    import ddr_cmd_pkg::*;
#(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int BL        = 8,
    parameter int TRCD      = 4,
    parameter int TRP       = 4,
    parameter int TREFI     = 3120,
    parameter int TRFC      = 88
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 halt,
    ddr_cmd_issuer_if.slave      req,
    output logic [CMD_WIDTH-1:0] commands,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba,
    output logic [ADDRWIDTH-1:0] row,
    output logic [COLWIDTH-1:0]  column,
    output logic                 busy
);
    localparam int TBURST = BL / 2;
    localparam int IDX_W  = BGWIDTH + BAWIDTH;
    localparam int CNT_W  = $clog2(max4(TRCD, TRP, TBURST, TRFC) + 1);

    localparam logic [CNT_W-1:0] LD_RP    = CNT_W'(TRP - 1);
    localparam logic [CNT_W-1:0] LD_RCD   = CNT_W'(TRCD - 1);
    localparam logic [CNT_W-1:0] LD_BURST = CNT_W'(TBURST - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [COLWIDTH-1:0]  in_col;
    logic [BGWIDTH-1:0]   in_bg;
    logic [BAWIDTH-1:0]   in_ba;
    logic [ADDRWIDTH-1:0] in_row;

    assign in_col = req.req_addr[COLWIDTH-1:0];
    assign in_bg  = req.req_addr[COLWIDTH +: BGWIDTH];
    assign in_ba  = req.req_addr[COLWIDTH+BGWIDTH +: BAWIDTH];
    assign in_row = req.req_addr[COLWIDTH+BGWIDTH+BAWIDTH +: ADDRWIDTH];

    ddr_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 lat_we_q;
    logic [BGWIDTH-1:0]   lat_bg_q;
    logic [BAWIDTH-1:0]   lat_ba_q;
    logic [ADDRWIDTH-1:0] lat_row_q, row_q;
    logic [COLWIDTH-1:0]  lat_col_q, col_q;
    // Keeps req_ready low until the first edge after reset release.
    logic                 out_en_q;

    logic accept, ready_c, rw_fire;
    logic tbl_set, tbl_clr, tbl_clr_all;
    logic lk_valid, lk_hit;
    logic refresh_pending;
    logic [CMD_WIDTH-1:0] cmd_c;

`ifdef REFRESH_EN
    localparam int                REFI_W  = $clog2(TREFI + 1);
    localparam logic [REFI_W-1:0] LD_REFI = REFI_W'(TREFI - 1);
    localparam logic [CNT_W-1:0]  LD_RFC  = CNT_W'(TRFC - 1);

    logic [REFI_W-1:0] refi_cnt_q;
    logic              ref_pend_q;
    logic              ref_clr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refi_cnt_q <= LD_REFI;
            ref_pend_q <= 1'b0;
        end else if (!halt) begin
            if (ref_clr) ref_pend_q <= 1'b0;
            if (refi_cnt_q == '0) begin
                refi_cnt_q <= LD_REFI;
                ref_pend_q <= 1'b1;
            end else begin
                refi_cnt_q <= refi_cnt_q - REFI_W'(1);
            end
        end
    end

    assign refresh_pending = ref_pend_q;
`else
    logic unused_refresh_params;
    assign unused_refresh_params = (TREFI == 0);
    assign refresh_pending       = 1'b0;
`endif

    ddr_open_row_table #(
        .IDX_W (IDX_W),
        .ROW_W (ADDRWIDTH)
    ) u_table (
        .clk        (clk),
        .rst_n      (reset_n),
        .lk_idx_i   ({in_bg, in_ba}),
        .lk_row_i   (in_row),
        .lk_valid_o (lk_valid),
        .lk_hit_o   (lk_hit),
        .wr_idx_i   ({lat_bg_q, lat_ba_q}),
        .set_en_i   (tbl_set),
        .set_row_i  (lat_row_q),
        .clr_en_i   (tbl_clr),
        .clr_all_i  (tbl_clr_all)
    );

    // Wait states exit on the edge where the counter reaches zero; a load
    // value of zero skips the wait state entirely.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_c       = '0;
        ready_c     = 1'b0;
        accept      = 1'b0;
        rw_fire     = 1'b0;
        tbl_set     = 1'b0;
        tbl_clr     = 1'b0;
        tbl_clr_all = 1'b0;
`ifdef REFRESH_EN
        ref_clr     = 1'b0;
`endif
        if (!halt) begin
            case (state_q)
                ST_IDLE: begin
                    ready_c = out_en_q && !refresh_pending;
                    if (refresh_pending) begin
                        state_d = ST_PREA;
                    end else if (req.req_valid && out_en_q) begin
                        accept = 1'b1;
                        if (lk_hit)        state_d = ST_RW;
                        else if (lk_valid) state_d = ST_PRE;
                        else               state_d = ST_ACT;
                    end
                end
                ST_PRE: begin
                    cmd_c[CMD_PRE] = 1'b1;
                    tbl_clr        = 1'b1;
                    cnt_d          = LD_RP;
                    state_d        = (LD_RP == '0) ? ST_ACT : ST_WAIT_RP;
                end
                ST_WAIT_RP: begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_d = ST_ACT;
                end
                ST_ACT: begin
                    cmd_c[CMD_ACT] = 1'b1;
                    tbl_set        = 1'b1;
                    cnt_d          = LD_RCD;
                    state_d        = (LD_RCD == '0) ? ST_RW : ST_WAIT_RCD;
                end
                ST_WAIT_RCD: begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_d = ST_RW;
                end
                ST_RW: begin
                    if (lat_we_q) cmd_c[CMD_WR] = 1'b1;
                    else          cmd_c[CMD_RD] = 1'b1;
                    rw_fire = 1'b1;
                    cnt_d   = LD_BURST;
                    state_d = (LD_BURST == '0) ? ST_IDLE : ST_WAIT_BURST;
                end
                ST_WAIT_BURST: begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_d = ST_IDLE;
                end
`ifdef REFRESH_EN
                ST_PREA: begin
                    cmd_c[CMD_PREA] = 1'b1;
                    tbl_clr_all     = 1'b1;
                    cnt_d           = LD_RP;
                    state_d         = (LD_RP == '0) ? ST_REF : ST_WAIT_RP_ALL;
                end
                ST_WAIT_RP_ALL: begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_d = ST_REF;
                end
                ST_REF: begin
                    cmd_c[CMD_REF] = 1'b1;
                    ref_clr        = 1'b1;
                    cnt_d          = LD_RFC;
                    state_d        = (LD_RFC == '0) ? ST_IDLE : ST_WAIT_RFC;
                end
                ST_WAIT_RFC: begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_d = ST_IDLE;
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            out_en_q  <= 1'b0;
            lat_we_q  <= 1'b0;
            lat_bg_q  <= '0;
            lat_ba_q  <= '0;
            lat_row_q <= '0;
            lat_col_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            out_en_q <= 1'b1;
            if (accept) begin
                lat_we_q  <= req.req_we;
                lat_bg_q  <= in_bg;
                lat_ba_q  <= in_ba;
                lat_row_q <= in_row;
                lat_col_q <= in_col;
            end
            if (tbl_set) row_q <= lat_row_q;
            if (rw_fire) col_q <= lat_col_q;
        end
    end

    assign req.req_ready = ready_c;
    assign commands      = cmd_c;
    assign bg            = lat_bg_q;
    assign ba            = lat_ba_q;
    // Show the latched row/column during their command cycle, then hold it.
    assign row           = (state_q == ST_ACT) ? lat_row_q : row_q;
    assign column        = (state_q == ST_RW)  ? lat_col_q : col_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ddr_cmd_issuer.sv
module tb_ddr_cmd_issuer;
    import ddr_cmd_pkg::*;

    localparam int AW = 31;

    logic                 clk;
    logic                 reset_n;
    logic                 halt;
    logic [CMD_WIDTH-1:0] commands;
    logic [1:0]           bg, ba;
    logic [16:0]          row;
    logic [9:0]           column;
    logic                 busy;

    int total = 0;
    int bad   = 0;

    int          t_act, t_pre, t_rw, t_rdy, n_act, n_onehot_bad, n_halt_bad;
    logic [16:0] act_row;
    logic [9:0]  rw_col;
    logic [1:0]  rw_bg, rw_ba;
    logic        rw_is_wr;

    ddr_cmd_issuer_if #(.AW(AW)) bus ();

    ddr_cmd_issuer #(
        .TREFI (64),
        .TRFC  (8)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .halt     (halt),
        .req      (bus),
        .commands (commands),
        .bg       (bg),
        .ba       (ba),
        .row      (row),
        .column   (column),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [AW-1:0] mk(input logic [16:0] r, input logic [1:0] a,
                                         input logic [1:0] g, input logic [9:0] c);
        return {r, a, g, c};
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.req_ready && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.req_ready) chk("ready_timeout", n, 0);
    endtask

    // Issue one request and record the cycle offset (acceptance edge T -> 0)
    // at which each command and the next req_ready appear.
    task automatic issue(input logic we, input logic [AW-1:0] addr,
                         input int h0, input int hl);
        t_act = -1; t_pre = -1; t_rw = -1; t_rdy = -1;
        n_act = 0; n_onehot_bad = 0; n_halt_bad = 0;
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        for (int off = 1; off <= 60; off++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            halt = (off >= h0) && (off < h0 + hl);
            #1;
            if (commands != '0) begin
                if ($countones(commands) != 1) n_onehot_bad++;
                if (halt) n_halt_bad++;
                if (commands[CMD_ACT]) begin
                    n_act++;
                    if (t_act < 0) begin t_act = off; act_row = row; end
                end
                if (commands[CMD_PRE] && t_pre < 0) t_pre = off;
                if ((commands[CMD_RD] || commands[CMD_WR]) && t_rw < 0) begin
                    t_rw = off; rw_is_wr = commands[CMD_WR];
                    rw_col = column; rw_bg = bg; rw_ba = ba;
                end
            end
            if (bus.req_ready) begin
                t_rdy = off;
                break;
            end
        end
        halt = 1'b0;
        chk("issue_onehot", n_onehot_bad, 0);
    endtask

    initial begin
        reset_n       = 1'b0;
        halt          = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_commands", commands, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_row", row, 0);
        chk("rst_column", column, 0);
        chk("rst_bgba", {bg, ba}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rel_ready", bus.req_ready, 1);
        chk("rel_busy", busy, 0);

        // read to closed bank bg1 ba2 row 0x55 col 0x10
        issue(1'b0, mk(17'h55, 2'd2, 2'd1, 10'h010), 0, 0);
        chk("rd_closed_t_act", t_act, 1);
        chk("rd_closed_row", act_row, 'h55);
        chk("rd_closed_t_pre", t_pre, -1);
        chk("rd_closed_t_rd", t_rw, 5);
        chk("rd_closed_is_wr", rw_is_wr, 0);
        chk("rd_closed_col", rw_col, 'h10);
        chk("rd_closed_bg", rw_bg, 1);
        chk("rd_closed_ba", rw_ba, 2);
        chk("rd_closed_t_rdy", t_rdy, 9);

        // write hit to the same row
        issue(1'b1, mk(17'h55, 2'd2, 2'd1, 10'h020), 0, 0);
        chk("wr_hit_t_act", t_act, -1);
        chk("wr_hit_t_wr", t_rw, 1);
        chk("wr_hit_is_wr", rw_is_wr, 1);
        chk("wr_hit_col", rw_col, 'h20);
        chk("wr_hit_t_rdy", t_rdy, 5);

        // read conflict: row 0xAA in the same bank
        issue(1'b0, mk(17'hAA, 2'd2, 2'd1, 10'h030), 0, 0);
        chk("rd_conf_t_pre", t_pre, 1);
        chk("rd_conf_t_act", t_act, 5);
        chk("rd_conf_row", act_row, 'hAA);
        chk("rd_conf_t_rd", t_rw, 9);
        chk("rd_conf_col", rw_col, 'h30);
        chk("rd_conf_t_rdy", t_rdy, 13);

        // halt while idle blocks acceptance
        halt = 1'b1;
        #1;
        chk("halt_idle_ready", bus.req_ready, 0);
        chk("halt_idle_cmd", commands, 0);
        @(negedge clk);
        halt = 1'b0;
        #1;

        // reset in the middle of a sequence
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = mk(17'h7, 2'd3, 2'd3, 10'h1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_cmd", commands, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", bus.req_ready, 0);
        chk("midrst_bg", bg, 0);
        chk("midrst_row", row, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_rel_ready", bus.req_ready, 1);

        // table was cleared by reset: row 0xAA needs ACT again
        issue(1'b0, mk(17'hAA, 2'd2, 2'd1, 10'h031), 0, 0);
        chk("post_rst_t_pre", t_pre, -1);
        chk("post_rst_t_act", t_act, 1);
        chk("post_rst_t_rd", t_rw, 5);

        // halt 3 cycles during WAIT_RCD
        issue(1'b0, mk(17'h123, 2'd0, 2'd0, 10'h044), 2, 3);
        chk("halt_t_act", t_act, 1);
        chk("halt_n_act", n_act, 1);
        chk("halt_cmd_zero", n_halt_bad, 0);
        chk("halt_t_rd", t_rw, 8);
        chk("halt_col", rw_col, 'h44);
        chk("halt_t_rdy", t_rdy, 12);

`ifdef REFRESH_EN
        begin
            int t_prea, t_ref, rdy_bad;
            t_prea = -1; t_ref = -1; rdy_bad = 0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                #1;
                if (commands[CMD_PREA] && t_prea < 0) t_prea = i;
                if (commands[CMD_REF] && t_ref < 0) t_ref = i;
                if (t_prea >= 0 && t_ref < 0 && bus.req_ready) rdy_bad++;
                if (t_ref >= 0 && !busy) break;
            end
            chk("ref_prea_seen", t_prea >= 0, 1);
            chk("ref_gap", t_ref - t_prea, 4);
            chk("ref_ready_low", rdy_bad, 0);
        end
        issue(1'b0, mk(17'hAA, 2'd2, 2'd1, 10'h011), 0, 0);
        chk("after_ref_t_pre", t_pre, -1);
        chk("after_ref_t_act", t_act, 1);
        chk("after_ref_t_rd", t_rw, 5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
